demux_3_reg: RTL

Registered 1-to-3 demultiplexer with valid/ready handshake: the write-side counterpart of the 32-bit 3-way select mux. It takes one 32-bit word plus a 2-bit destination code and delivers it, one cycle later, to exactly one of three consumers (e.g. register file write port, data memory, I/O). Destination code 2'b11 is invalid; such words are accepted and discarded. It sits between the execute/writeback producer and its three sinks, and provides one stage of buffering with full-throughput flow control.

---
 rtl/demux_3_reg_pkg.sv | 31 +++
 rtl/demux_3_reg_sat_cnt8.sv | 19 +
 rtl/demux_3_reg.sv | 78 +++++++
 3 files changed

// File: rtl/demux_3_reg_pkg.sv
// Shared definitions for demux_3_reg: destination codes, drop counter width,
// holding-register states and the destination decode helper.
package demux_3_reg_pkg;

    localparam logic [1:0] DEST_0    = 2'b00;
    localparam logic [1:0] DEST_1    = 2'b01;
    localparam logic [1:0] DEST_2    = 2'b10;
    localparam logic [1:0] DEST_NONE = 2'b11;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned NUM_SINKS  = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Destination code to one-hot sink strobe; DEST_NONE maps to no sink.
    function automatic logic [NUM_SINKS-1:0] dest_onehot(input logic [1:0] sel);
        logic [NUM_SINKS-1:0] oh;
        oh = '0;
        case (sel)
            DEST_0:  oh = 3'b001;
            DEST_1:  oh = 3'b010;
            DEST_2:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_3_reg_sat_cnt8.sv
// sat_cnt8: 8-bit saturating event counter with async active-low clear.
module sat_cnt8
    import demux_3_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [DROP_CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {DROP_CNT_W{1'b1}})) begin
            cnt <= cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_3_reg.sv
// Registered 1-to-3 demux with valid/ready flow control and one word of buffering.
// Optional drop counter for invalid-destination words: define DEMUX_3_REG_DROP_CNT_EN.
module demux_3_reg
    import demux_3_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [NUM_SINKS-1:0]  out_valid,
    input  logic [NUM_SINKS-1:0]  out_ready
`ifdef DEMUX_3_REG_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold_data_q;
    logic [1:0]       hold_sel_q;
    logic             drain;
    logic             accept;
    logic             load;

    // State register and holding register; data/sel only move on a routed accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_sel_q  <= DEST_0;
        end else begin
            state_q <= state_d;
            if (load) begin
                hold_data_q <= in_data;
                hold_sel_q  <= in_sel;
            end
        end
    end

    assign out_data  = hold_data_q;
    assign out_valid = (state_q == ST_FULL) ? dest_onehot(hold_sel_q) : '0;

    // Only the addressed sink's ready can drain the held word.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        drain    = (state_q == ST_FULL) && ((out_valid & out_ready) != '0);
        in_ready = (state_q == ST_EMPTY) || drain;
        accept   = in_valid && in_ready;

        if (accept && (in_sel != DEST_NONE)) begin
            load    = 1'b1;
            state_d = ST_FULL;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

`ifdef DEMUX_3_REG_DROP_CNT_EN
    logic drop;

    assign drop = accept && (in_sel == DEST_NONE);

    sat_cnt8 u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop),
        .cnt   (drop_cnt)
    );
`endif

endmodule
